// File: rtl/gpio_in_filter_pkg.sv
// gpio_in_filter_pkg: shared defaults and per-pin state type for the GPIO
// input conditioning stage.
package gpio_in_filter_pkg;

  localparam int unsigned GPIO_NUM_DEF  = 8;
  localparam int unsigned CNT_WIDTH_DEF = 8;

  // Per-pin state held after the synchroniser.
  typedef struct packed {
    logic stable;  // filtered level
    logic prev;    // filtered level one cycle ago, for edge detection
    logic pend;    // sticky interrupt pending
  } gpio_in_state_t;

endpackage

// File: rtl/gpio_in_filter_bit.sv
// gpio_in_filter_bit: one pin's synchroniser, optional debounce, edge
// detect and sticky pending flag.
// Build option: GPIO_IN_FILTER_DBC_EN enables the debounce counter; when
// undefined the filtered level follows the synchroniser with no delay
// and dbc_thr_i is ignored.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   c_i               raw pad input (asynchronous)
//   dbc_thr_i         debounce threshold
//   rise_en_i/fall_en_i  edge interrupt enables
//   irq_clr_i         pending clear pulse
//   data_o            filtered level
//   rise_o/fall_o     one-cycle edge strobes
//   pend_o            sticky pending flag
module gpio_in_filter_bit
  import gpio_in_filter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 c_i,
  input  logic [CNT_WIDTH-1:0] dbc_thr_i,
  input  logic                 rise_en_i,
  input  logic                 fall_en_i,
  input  logic                 irq_clr_i,
  output logic                 data_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 pend_o
);

  logic           s1;
  logic           s2;
  logic           stable_d;
  logic           rise_c;
  logic           fall_c;
  gpio_in_state_t st_q;
  gpio_in_state_t st_d;

  // Two-flop resynchroniser.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= c_i;
      s2 <= s1;
    end
  end

`ifdef GPIO_IN_FILTER_DBC_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Accept a new level once it has differed for more than dbc_thr_i cycles;
  // any return to the current level restarts the count.
  always_comb begin
    stable_d = st_q.stable;
    cnt_d    = '0;
    if (s2 != st_q.stable) begin
      if (cnt_q >= dbc_thr_i) begin
        stable_d = s2;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_thr;

  assign stable_d   = s2;
  assign unused_thr = ^dbc_thr_i;
`endif

  assign rise_c = st_q.stable & ~st_q.prev;
  assign fall_c = ~st_q.stable & st_q.prev;

  // Next state: a new enabled edge sets pending even if cleared this cycle.
  always_comb begin
    st_d        = st_q;
    st_d.stable = stable_d;
    st_d.prev   = st_q.stable;
    st_d.pend   = (rise_c & rise_en_i) | (fall_c & fall_en_i) |
                  (st_q.pend & ~irq_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign data_o = st_q.stable;
  assign rise_o = rise_c;
  assign fall_o = fall_c;
  assign pend_o = st_q.pend;

endmodule

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-pin input conditioning downstream of the GPIO pads.
// Resynchronises, optionally debounces and edge-detects every pin, latching
// enabled edges into sticky pending bits ORed into one interrupt.
// Build option: GPIO_IN_FILTER_DBC_EN enables the debounce filter.
// Ports:
//   clk_i, rst_i      core clock, async active-high reset
//   c_i               raw pad inputs
//   dbc_thr_i         shared debounce threshold (quasi-static)
//   rise_en_i/fall_en_i  per-pin edge interrupt enables
//   irq_clr_i         per-pin write-1-to-clear pulse
//   data_o            filtered levels
//   rise_o/fall_o     one-cycle edge strobes
//   pend_o            sticky pending flags
//   irq_o             OR of pend_o
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int unsigned GPIO_NUM  = GPIO_NUM_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [GPIO_NUM-1:0]  c_i,
  input  logic [CNT_WIDTH-1:0] dbc_thr_i,
  input  logic [GPIO_NUM-1:0]  rise_en_i,
  input  logic [GPIO_NUM-1:0]  fall_en_i,
  input  logic [GPIO_NUM-1:0]  irq_clr_i,
  output logic [GPIO_NUM-1:0]  data_o,
  output logic [GPIO_NUM-1:0]  rise_o,
  output logic [GPIO_NUM-1:0]  fall_o,
  output logic [GPIO_NUM-1:0]  pend_o,
  output logic                 irq_o
);

  logic [CNT_WIDTH-1:0] thr;

`ifdef GPIO_IN_FILTER_DBC_EN
  assign thr = dbc_thr_i;
`else
  logic unused_thr;

  assign thr        = '0;
  assign unused_thr = ^dbc_thr_i;
`endif

  for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
    gpio_in_filter_bit #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_bit (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .c_i       (c_i[i]),
      .dbc_thr_i (thr),
      .rise_en_i (rise_en_i[i]),
      .fall_en_i (fall_en_i[i]),
      .irq_clr_i (irq_clr_i[i]),
      .data_o    (data_o[i]),
      .rise_o    (rise_o[i]),
      .fall_o    (fall_o[i]),
      .pend_o    (pend_o[i])
    );
  end

  assign irq_o = |pend_o;

endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: directed self-checking bench for gpio_in_filter.
module tb_gpio_in_filter;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  c;
  logic [CW-1:0] thr;
  logic [N-1:0]  rise_en;
  logic [N-1:0]  fall_en;
  logic [N-1:0]  irq_clr;
  logic [N-1:0]  data;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [N-1:0]  pend;
  logic          irq;

  int checks;
  int failures;

  gpio_in_filter #(
    .GPIO_NUM  (N),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .c_i       (c),
    .dbc_thr_i (thr),
    .rise_en_i (rise_en),
    .fall_en_i (fall_en),
    .irq_clr_i (irq_clr),
    .data_o    (data),
    .rise_o    (rise),
    .fall_o    (fall),
    .pend_o    (pend),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Effective debounce threshold for the build under test.
  function automatic int teff(input logic [CW-1:0] t);
`ifdef GPIO_IN_FILTER_DBC_EN
    return int'(t);
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; c = '0; thr = '0; rise_en = '0; fall_en = '0; irq_clr = '0;
    ticks(2);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_init_data got=%h exp=00", data); end
    checks++; if ({rise, fall, pend, irq} !== 25'h0) begin failures++; $display("FAIL reset_init_flags got=%h exp=0", {rise, fall, pend, irq}); end
    #2 rst = 1'b0;
    ticks(3);
    c = 8'hFF; rise_en = 8'hFF;
    ticks(3);
    checks++; if (data !== 8'hFF) begin failures++; $display("FAIL reset_pre_data got=%h exp=ff", data); end
    tick();
    checks++; if (pend !== 8'hFF || irq !== 1'b1) begin failures++; $display("FAIL reset_pre_pend got=%h/%b exp=ff/1", pend, irq); end
    // Asynchronous assertion mid-cycle.
    #2 rst = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_async_data got=%h exp=00", data); end
    checks++; if ({rise, fall, pend, irq} !== 25'h0) begin failures++; $display("FAIL reset_async_flags got=%h exp=0", {rise, fall, pend, irq}); end
    tick();
    #2 rst = 1'b0;
    ticks(2);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_rel_early got=%h exp=00", data); end
    tick();
    checks++; if (data !== 8'hFF || rise !== 8'hFF) begin failures++; $display("FAIL reset_rel_rise got=%h/%h exp=ff/ff", data, rise); end
    tick();
    checks++; if (rise !== 8'h00 || pend !== 8'hFF) begin failures++; $display("FAIL reset_rel_after got=%h/%h exp=00/ff", rise, pend); end
    rise_en = '0; irq_clr = 8'hFF;
    tick();
    irq_clr = '0;
    checks++; if (pend !== 8'h00 || irq !== 1'b0) begin failures++; $display("FAIL reset_clear got=%h/%b exp=00/0", pend, irq); end
  endtask

  task automatic test_threshold();
    int t;
    thr = 8'd4; t = teff(thr);
    c = 8'hFE;
    ticks(t + 6);
    checks++; if (data !== 8'hFE) begin failures++; $display("FAIL thr_setup got=%h exp=fe", data); end
    c = 8'hFF;
    ticks(t + 2);
    checks++; if (data[0] !== 1'b0) begin failures++; $display("FAIL thr_early got=%b exp=0", data[0]); end
    tick();
    checks++; if (data[0] !== 1'b1 || rise !== 8'h01 || fall !== 8'h00) begin failures++; $display("FAIL thr_edge data=%b rise=%h fall=%h exp=1/01/00", data[0], rise, fall); end
    tick();
    checks++; if (rise !== 8'h00 || fall !== 8'h00 || data[0] !== 1'b1) begin failures++; $display("FAIL thr_after data=%b rise=%h fall=%h exp=1/00/00", data[0], rise, fall); end
  endtask

  task automatic test_glitch();
    int t;
    bit bad;
    thr = 8'd4; t = teff(thr);
    c = 8'hFD;
    ticks(t + 6);
    irq_clr = 8'hFF; tick(); irq_clr = '0;
    rise_en = 8'h02;
    checks++; if (data !== 8'hFD || pend !== 8'h00) begin failures++; $display("FAIL glitch_setup got=%h/%h exp=fd/00", data, pend); end
`ifdef GPIO_IN_FILTER_DBC_EN
    // Pulse one cycle too short to be accepted.
    c = 8'hFF; ticks(t); c = 8'hFD;
    bad = 1'b0;
    for (int i = 0; i < 2 * t + 6; i++) begin
      tick();
      if (data[1] !== 1'b0 || rise[1] !== 1'b0 || pend[1] !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL glitch_reject data=%b rise=%b pend=%b exp=0/0/0", data[1], rise[1], pend[1]); end
`endif
    // Pulse just long enough: rise, then fall.
    c = 8'hFF; ticks(t + 1); c = 8'hFD;
    ticks(1);
    checks++; if (data[1] !== 1'b0) begin failures++; $display("FAIL glitch_pass_early got=%b exp=0", data[1]); end
    ticks(1);
    checks++; if (data[1] !== 1'b1 || rise !== 8'h02) begin failures++; $display("FAIL glitch_pass_rise data=%b rise=%h exp=1/02", data[1], rise); end
    ticks(t + 1);
    checks++; if (data[1] !== 1'b0 || fall !== 8'h02) begin failures++; $display("FAIL glitch_pass_fall data=%b fall=%h exp=0/02", data[1], fall); end
    checks++; if (pend !== 8'h02) begin failures++; $display("FAIL glitch_pass_pend got=%h exp=02", pend); end
  endtask

  task automatic test_pend_irq();
    int t;
    t = teff(thr);
    rise_en = '0; fall_en = '0;
    c = 8'hFE;
    ticks(t + 6);
    irq_clr = 8'hFF; tick(); irq_clr = '0;
    checks++; if (data !== 8'hFE || pend !== 8'h00 || irq !== 1'b0) begin failures++; $display("FAIL pend_setup got=%h/%h/%b exp=fe/00/0", data, pend, irq); end
    rise_en = 8'h01; fall_en = 8'h02;
    c = 8'hFD;
    ticks(t + 3);
    checks++; if (rise !== 8'h01 || fall !== 8'h02 || pend !== 8'h00) begin failures++; $display("FAIL pend_strobe rise=%h fall=%h pend=%h exp=01/02/00", rise, fall, pend); end
    tick();
    checks++; if (pend !== 8'h03 || irq !== 1'b1) begin failures++; $display("FAIL pend_set got=%h/%b exp=03/1", pend, irq); end
    irq_clr = 8'h01; tick(); irq_clr = '0;
    checks++; if (pend !== 8'h02 || irq !== 1'b1) begin failures++; $display("FAIL pend_clr0 got=%h/%b exp=02/1", pend, irq); end
    fall_en = '0; rise_en = '0;
    tick();
    checks++; if (pend !== 8'h02) begin failures++; $display("FAIL pend_en_off got=%h exp=02", pend); end
    irq_clr = 8'h02; tick(); irq_clr = '0;
    checks++; if (pend !== 8'h00 || irq !== 1'b0) begin failures++; $display("FAIL pend_clr1 got=%h/%b exp=00/0", pend, irq); end
  endtask

  task automatic test_set_wins();
    int t;
    t = teff(thr);
    rise_en = '0; fall_en = '0;
    c = 8'hFC;
    ticks(t + 6);
    rise_en = 8'h01;
    c = 8'hFD;
    ticks(t + 3);
    checks++; if (rise !== 8'h01) begin failures++; $display("FAIL setwins_strobe got=%h exp=01", rise); end
    irq_clr = 8'h01; tick(); irq_clr = '0;
    checks++; if (pend[0] !== 1'b1) begin failures++; $display("FAIL setwins_pend got=%b exp=1", pend[0]); end
    irq_clr = 8'h01; tick(); irq_clr = '0;
    checks++; if (pend !== 8'h00) begin failures++; $display("FAIL setwins_clear got=%h exp=00", pend); end
    rise_en = '0;
  endtask

  task automatic test_thr_max();
    int t;
    thr = 8'd0;
    c = 8'hF9;
    ticks(6);
    checks++; if (data !== 8'hF9) begin failures++; $display("FAIL thrmax_setup got=%h exp=f9", data); end
    thr = 8'hFF; t = teff(thr);
    c = 8'hFD;
    ticks(t + 2);
    checks++; if (data[2] !== 1'b0) begin failures++; $display("FAIL thrmax_early got=%b exp=0", data[2]); end
    tick();
    checks++; if (data[2] !== 1'b1 || rise !== 8'h04) begin failures++; $display("FAIL thrmax_edge data=%b rise=%h exp=1/04", data[2], rise); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_threshold();
    test_glitch();
    test_pend_irq();
    test_set_wins();
    test_thr_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
# gpio_in_filter

Per-pin input conditioning stage sitting directly downstream of the tri-state GPIO pad cells: it consumes each pad's `c_o` core-side input and turns it into clean, clock-domain-safe level, edge and interrupt information for the GPIO register block. Each pin is resynchronised, optionally debounced with a programmable stability threshold, and edge-detected. Enabled edges latch into sticky pending bits that drive a single interrupt line.

## Interface
- `GPIO_NUM`, default 8: number of pins handled.
- `CNT_WIDTH`, default 8: width of the debounce counter and threshold.
- `clk_i` input, 1 bit: core clock.
- `rst_i` input, 1 bit: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `c_i` input, `GPIO_NUM` bits: raw pad inputs from the pad `c_o` pins; asynchronous to `clk_i`.
- `dbc_thr_i` input, `CNT_WIDTH` bits: debounce threshold, shared by all pins; quasi-static.
- `rise_en_i` input, `GPIO_NUM` bits: per-pin rising-edge interrupt enable.
- `fall_en_i` input, `GPIO_NUM` bits: per-pin falling-edge interrupt enable.
- `irq_clr_i` input, `GPIO_NUM` bits: per-pin pending clear, one-cycle pulse (write-1-to-clear).
- `data_o` output, `GPIO_NUM` bits: filtered pin level.
- `rise_o` output, `GPIO_NUM` bits: one-cycle rising-edge strobe.
- `fall_o` output, `GPIO_NUM` bits: one-cycle falling-edge strobe.
- `pend_o` output, `GPIO_NUM` bits: sticky pending flags.
- `irq_o` output, 1 bit: OR of `pend_o`.

## Operation
- **Synchroniser:** two flops per pin, `c_i` → `s1` → `s2`. Reset value is 0.
- **Debounce, per pin:** registers `stable` (drives `data_o`) and `cnt`.
  - If `s2 == stable`: `cnt` is set to 0.
  - Else, if `cnt >= dbc_thr_i`: `stable` is set to `s2` and `cnt` is set to 0.
  - Otherwise `cnt` increments.
  - `cnt` never exceeds `dbc_thr_i`, so there is no wrap.
  - Lowering `dbc_thr_i` mid-count takes effect on the next compare (`>=`).
- **Edge detect:** register `prev` is loaded with `stable` every cycle.
  - `rise_o = stable & ~prev`.
  - `fall_o = ~stable & prev`.
  - Each strobe is high exactly one cycle, in the first cycle `data_o` shows the new level.
- **Pending:** `pend` is set on `(rise_o & rise_en_i) | (fall_o & fall_en_i)` and cleared by `irq_clr_i`.
  - Simultaneous set and clear on the same pin: set wins.
  - Enables do not clear existing pending bits.
- `irq_o = |pend`, combinational from flops, with no extra latency.
- **Reset:** all flops are 0. `data_o`, `rise_o`, `fall_o`, `pend_o` and `irq_o` are 0.
  - A pin held high through reset release produces a rise strobe once filtered. This is intended.
- **Reset mid-debounce:** the count is discarded; `stable` returns to 0.

## Timing
- Latency from a `c_i` change (captured by `s1` at edge N) to `data_o`, `rise_o` and `fall_o` updating: visible after edge N+2+T, where T = `dbc_thr_i`.
- With `dbc_thr_i = 0`: filtered output follows `s2` one cycle later.
- A glitch shorter than T+1 consecutive `s2` cycles never reaches `data_o`.
- `pend_o` rises one cycle after the strobe. `irq_o` follows in the same cycle as `pend_o`.
- `irq_clr_i` at edge M: `pend_o` is low after M, unless a new enabled edge strobes in that cycle.

## Configuration
- Macro: `GPIO_IN_FILTER_DBC_EN`.
- **Defined:** debounce logic as above.
- **Undefined:**
  - `cnt` and the compare are not built; `stable` is loaded with `s2` every cycle.
  - Latency is fixed at T=0.
  - `dbc_thr_i` is ignored and left unconnected internally.
  - All other behaviour is identical.

## Structure
- Shared package `gpio_in_filter_pkg`:
  - `GPIO_NUM_DEF` and `CNT_WIDTH_DEF` default constants.
  - `gpio_in_state_t` typedef: struct of `stable`, `prev` and `pend` per pin.
- Sub-module `gpio_in_filter_bit`: one pin's synchroniser, debounce, edge and pending logic.
- Top level: generate loop over `GPIO_NUM` instances, plus the `irq_o` OR-reduce.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle with `c_i = 8'hFF`. Required response: all outputs drop to 0 immediately. After release with T=0, `data_o = 8'hFF` and `rise_o = 8'hFF` for one cycle, 3 cycles later.
- **Threshold:** T=4, pin0 steps 0→1. Required response: `data_o[0]` rises at exactly edge N+6; `rise_o[0]` is high one cycle; `fall_o` stays 0.
- **Glitch rejection:** T=4, pin1 pulses high for 4 `s2` cycles. Required response: `data_o[1]`, `rise_o[1]` and `pend_o[1]` remain 0. A 5-cycle pulse produces a rise, then a fall.
- **Pending and interrupt:** `rise_en_i = 8'h01`, `fall_en_i = 8'h02`. Pin0 rises and pin1 falls. Required response: `pend_o = 8'h03` and `irq_o = 1`. Pulse `irq_clr_i = 8'h01`: `pend_o = 8'h02`, `irq_o` still 1.
- **Set-wins:** `irq_clr_i[0]` pulses in the same cycle as `rise_o[0]` with `rise_en_i[0] = 1`. Required response: `pend_o[0]` is 1 afterwards.
- **Macro off:** build without `GPIO_IN_FILTER_DBC_EN` and drive `dbc_thr_i = 8'hFF`. Required response: the edge appears on `data_o` after 3 cycles.
